// File: rtl/mem_lsu_stage.sv
// MEM pipeline stage: runs EX-bundle loads/stores on a valid/ready data port and registers the WB bundle.
// Build option MEM_ALE_CHECK_EN: misaligned accesses retire without a memory request and pulse ale.
module mem_lsu_stage #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int LSU_OP_WIDTH   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [31:0]               in_inst,
   input  logic [ADDR_WIDTH-1:0]     in_pc,
   input  logic [ADDR_WIDTH-1:0]     in_ex_result,
   input  logic                      in_rw_en,
   input  logic [REG_ADDR_WIDTH-1:0] in_rw_addr,
   input  logic [DATA_WIDTH-1:0]     in_lsu_data,
   input  logic [LSU_OP_WIDTH-1:0]   in_lsu_op,
   output logic                      dreq_valid,
   input  logic                      dreq_ready,
   output logic                      dreq_we,
   output logic [ADDR_WIDTH-1:0]     dreq_addr,
   output logic [DATA_WIDTH-1:0]     dreq_wdata,
   output logic [3:0]                dreq_wstrb,
   input  logic                      drsp_valid,
   input  logic [DATA_WIDTH-1:0]     drsp_rdata,
   output logic                      wb_valid,
   output logic [31:0]               wb_inst,
   output logic [ADDR_WIDTH-1:0]     wb_pc,
   output logic                      wb_rw_en,
   output logic [REG_ADDR_WIDTH-1:0] wb_rw_addr,
   output logic [DATA_WIDTH-1:0]     wb_rw_data
`ifdef MEM_ALE_CHECK_EN
   ,
   output logic                      ale
`endif
);

   localparam logic [LSU_OP_WIDTH-1:0] OP_LD_B  = LSU_OP_WIDTH'(1);
   localparam logic [LSU_OP_WIDTH-1:0] OP_LD_H  = LSU_OP_WIDTH'(2);
   localparam logic [LSU_OP_WIDTH-1:0] OP_LD_W  = LSU_OP_WIDTH'(3);
   localparam logic [LSU_OP_WIDTH-1:0] OP_LD_BU = LSU_OP_WIDTH'(4);
   localparam logic [LSU_OP_WIDTH-1:0] OP_LD_HU = LSU_OP_WIDTH'(5);
   localparam logic [LSU_OP_WIDTH-1:0] OP_ST_B  = LSU_OP_WIDTH'(6);
   localparam logic [LSU_OP_WIDTH-1:0] OP_ST_H  = LSU_OP_WIDTH'(7);
   localparam logic [LSU_OP_WIDTH-1:0] OP_ST_W  = LSU_OP_WIDTH'(8);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t                    state_q, state_d;
   logic [31:0]               inst_q, inst_d;
   logic [ADDR_WIDTH-1:0]     pc_q, pc_d;
   logic [ADDR_WIDTH-1:0]     ex_result_q, ex_result_d;
   logic                      rw_en_q, rw_en_d;
   logic [REG_ADDR_WIDTH-1:0] rw_addr_q, rw_addr_d;
   logic [LSU_OP_WIDTH-1:0]   op_q, op_d;

   logic                      dreq_valid_d, dreq_we_d;
   logic [ADDR_WIDTH-1:0]     dreq_addr_d;
   logic [DATA_WIDTH-1:0]     dreq_wdata_d;
   logic [3:0]                dreq_wstrb_d;
   logic                      wb_valid_d, wb_rw_en_d;
   logic [31:0]               wb_inst_d;
   logic [ADDR_WIDTH-1:0]     wb_pc_d;
   logic [REG_ADDR_WIDTH-1:0] wb_rw_addr_d;
   logic [DATA_WIDTH-1:0]     wb_rw_data_d;

   logic                      in_is_load, in_is_store, in_is_half, in_is_word;
   logic [1:0]                in_lane;
   logic [DATA_WIDTH-1:0]     st_wdata;
   logic [3:0]                st_wstrb;
   logic [7:0]                ld_byte;
   logic [15:0]               ld_half;
   logic [DATA_WIDTH-1:0]     ld_data;

`ifdef MEM_ALE_CHECK_EN
   logic                      ale_d;
   logic                      in_misaligned;

   assign in_misaligned = (in_is_half && in_ex_result[0]) ||
                          (in_is_word && (in_ex_result[1:0] != 2'b00));
`endif

   // Held in reset the stage must look stalled, so reset gates the ready flag directly.
   assign in_ready = rst && (state_q == IDLE);

   // Undefined op codes fall outside both ranges and therefore behave as NONE.
   always_comb begin
      in_is_load  = (in_lsu_op >= OP_LD_B) && (in_lsu_op <= OP_LD_HU);
      in_is_store = (in_lsu_op >= OP_ST_B) && (in_lsu_op <= OP_ST_W);
      in_is_half  = (in_lsu_op == OP_LD_H) || (in_lsu_op == OP_LD_HU) || (in_lsu_op == OP_ST_H);
      in_is_word  = (in_lsu_op == OP_LD_W) || (in_lsu_op == OP_ST_W);
      in_lane     = in_ex_result[1:0];
      if (in_is_half) in_lane[0] = 1'b0;
      if (in_is_word) in_lane = 2'b00;
   end

   always_comb begin
      st_wdata = '0;
      st_wstrb = 4'b0000;
      case (in_lsu_op)
         OP_ST_B: begin
            st_wdata = {4{in_lsu_data[7:0]}};
            st_wstrb = 4'b0001 << in_lane;
         end
         OP_ST_H: begin
            st_wdata = {2{in_lsu_data[15:0]}};
            st_wstrb = in_lane[1] ? 4'b1100 : 4'b0011;
         end
         OP_ST_W: begin
            st_wdata = in_lsu_data;
            st_wstrb = 4'b1111;
         end
         default: ;
      endcase
   end

   // The lane for extraction comes from dreq_addr, which still holds the aligned request address.
   always_comb begin
      case (dreq_addr[1:0])
         2'd0:    ld_byte = drsp_rdata[7:0];
         2'd1:    ld_byte = drsp_rdata[15:8];
         2'd2:    ld_byte = drsp_rdata[23:16];
         default: ld_byte = drsp_rdata[31:24];
      endcase
      ld_half = dreq_addr[1] ? drsp_rdata[31:16] : drsp_rdata[15:0];
      case (op_q)
         OP_LD_B:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         OP_LD_BU: ld_data = {24'd0, ld_byte};
         OP_LD_H:  ld_data = {{16{ld_half[15]}}, ld_half};
         OP_LD_HU: ld_data = {16'd0, ld_half};
         default:  ld_data = drsp_rdata;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      inst_d       = inst_q;
      pc_d         = pc_q;
      ex_result_d  = ex_result_q;
      rw_en_d      = rw_en_q;
      rw_addr_d    = rw_addr_q;
      op_d         = op_q;
      dreq_valid_d = dreq_valid;
      dreq_we_d    = dreq_we;
      dreq_addr_d  = dreq_addr;
      dreq_wdata_d = dreq_wdata;
      dreq_wstrb_d = dreq_wstrb;
      wb_valid_d   = 1'b0;
      wb_inst_d    = wb_inst;
      wb_pc_d      = wb_pc;
      wb_rw_en_d   = wb_rw_en;
      wb_rw_addr_d = wb_rw_addr;
      wb_rw_data_d = wb_rw_data;
`ifdef MEM_ALE_CHECK_EN
      ale_d        = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               inst_d      = in_inst;
               pc_d        = in_pc;
               ex_result_d = in_ex_result;
               rw_en_d     = in_rw_en;
               rw_addr_d   = in_rw_addr;
               op_d        = in_lsu_op;
               if (!(in_is_load || in_is_store)) begin
                  wb_valid_d   = 1'b1;
                  wb_inst_d    = in_inst;
                  wb_pc_d      = in_pc;
                  wb_rw_en_d   = in_rw_en;
                  wb_rw_addr_d = in_rw_addr;
                  wb_rw_data_d = DATA_WIDTH'(in_ex_result);
               end
`ifdef MEM_ALE_CHECK_EN
               else if (in_misaligned) begin
                  wb_valid_d   = 1'b1;
                  ale_d        = 1'b1;
                  wb_inst_d    = in_inst;
                  wb_pc_d      = in_pc;
                  wb_rw_en_d   = 1'b0;
                  wb_rw_addr_d = in_rw_addr;
                  wb_rw_data_d = DATA_WIDTH'(in_ex_result);
               end
`endif
               else begin
                  state_d      = REQ;
                  dreq_valid_d = 1'b1;
                  dreq_we_d    = in_is_store;
                  dreq_addr_d  = {in_ex_result[ADDR_WIDTH-1:2], in_lane};
                  dreq_wdata_d = st_wdata;
                  dreq_wstrb_d = st_wstrb;
               end
            end
         end
         REQ: begin
            if (dreq_ready) begin
               dreq_valid_d = 1'b0;
               if (dreq_we) begin
                  state_d      = IDLE;
                  wb_valid_d   = 1'b1;
                  wb_inst_d    = inst_q;
                  wb_pc_d      = pc_q;
                  wb_rw_en_d   = 1'b0;
                  wb_rw_addr_d = rw_addr_q;
                  wb_rw_data_d = DATA_WIDTH'(ex_result_q);
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (drsp_valid) begin
               state_d      = IDLE;
               wb_valid_d   = 1'b1;
               wb_inst_d    = inst_q;
               wb_pc_d      = pc_q;
               wb_rw_en_d   = rw_en_q;
               wb_rw_addr_d = rw_addr_q;
               wb_rw_data_d = ld_data;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         inst_q      <= '0;
         pc_q        <= '0;
         ex_result_q <= '0;
         rw_en_q     <= 1'b0;
         rw_addr_q   <= '0;
         op_q        <= '0;
         dreq_valid  <= 1'b0;
         dreq_we     <= 1'b0;
         dreq_addr   <= '0;
         dreq_wdata  <= '0;
         dreq_wstrb  <= 4'b0000;
         wb_valid    <= 1'b0;
         wb_inst     <= '0;
         wb_pc       <= '0;
         wb_rw_en    <= 1'b0;
         wb_rw_addr  <= '0;
         wb_rw_data  <= '0;
`ifdef MEM_ALE_CHECK_EN
         ale         <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         inst_q      <= inst_d;
         pc_q        <= pc_d;
         ex_result_q <= ex_result_d;
         rw_en_q     <= rw_en_d;
         rw_addr_q   <= rw_addr_d;
         op_q        <= op_d;
         dreq_valid  <= dreq_valid_d;
         dreq_we     <= dreq_we_d;
         dreq_addr   <= dreq_addr_d;
         dreq_wdata  <= dreq_wdata_d;
         dreq_wstrb  <= dreq_wstrb_d;
         wb_valid    <= wb_valid_d;
         wb_inst     <= wb_inst_d;
         wb_pc       <= wb_pc_d;
         wb_rw_en    <= wb_rw_en_d;
         wb_rw_addr  <= wb_rw_addr_d;
         wb_rw_data  <= wb_rw_data_d;
`ifdef MEM_ALE_CHECK_EN
         ale         <= ale_d;
`endif
      end
   end

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Bench for mem_lsu_stage: directed vector table, hand-written corner sequences and
// randomized transactions checked against a spec-level reference model.
`timescale 1ns/1ps
module tb_mem_lsu_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic [31:0] in_ex_result;
   logic        in_rw_en;
   logic [4:0]  in_rw_addr;
   logic [31:0] in_lsu_data;
   logic [3:0]  in_lsu_op;
   logic        dreq_valid;
   logic        dreq_ready;
   logic        dreq_we;
   logic [31:0] dreq_addr;
   logic [31:0] dreq_wdata;
   logic [3:0]  dreq_wstrb;
   logic        drsp_valid;
   logic [31:0] drsp_rdata;
   logic        wb_valid;
   logic [31:0] wb_inst;
   logic [31:0] wb_pc;
   logic        wb_rw_en;
   logic [4:0]  wb_rw_addr;
   logic [31:0] wb_rw_data;
`ifdef MEM_ALE_CHECK_EN
   logic        ale;
`endif

   int nVectors     = 0;
   int nMiscompares = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] rdata;
      logic [31:0] inst;
      logic [31:0] pc;
      logic        rw_en;
      logic [4:0]  rw_addr;
      int          ready_dly;
      int          rsp_dly;
      bit          hold_valid;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_wstrb;
      logic [31:0] exp_rw_data;
      bit          exp_ale;
   } vec_t;

   vec_t vecs[$];

   mem_lsu_stage dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_inst      (in_inst),
      .in_pc        (in_pc),
      .in_ex_result (in_ex_result),
      .in_rw_en     (in_rw_en),
      .in_rw_addr   (in_rw_addr),
      .in_lsu_data  (in_lsu_data),
      .in_lsu_op    (in_lsu_op),
      .dreq_valid   (dreq_valid),
      .dreq_ready   (dreq_ready),
      .dreq_we      (dreq_we),
      .dreq_addr    (dreq_addr),
      .dreq_wdata   (dreq_wdata),
      .dreq_wstrb   (dreq_wstrb),
      .drsp_valid   (drsp_valid),
      .drsp_rdata   (drsp_rdata),
      .wb_valid     (wb_valid),
      .wb_inst      (wb_inst),
      .wb_pc        (wb_pc),
      .wb_rw_en     (wb_rw_en),
      .wb_rw_addr   (wb_rw_addr),
      .wb_rw_data   (wb_rw_data)
`ifdef MEM_ALE_CHECK_EN
      ,
      .ale          (ale)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_in_ready"}, in_ready, 0);
      checkOutput({tag, "_dreq_valid"}, dreq_valid, 0);
      checkOutput({tag, "_dreq_we"}, dreq_we, 0);
      checkOutput({tag, "_dreq_addr"}, dreq_addr, 0);
      checkOutput({tag, "_dreq_wdata"}, dreq_wdata, 0);
      checkOutput({tag, "_dreq_wstrb"}, dreq_wstrb, 0);
      checkOutput({tag, "_wb_valid"}, wb_valid, 0);
      checkOutput({tag, "_wb_inst"}, wb_inst, 0);
      checkOutput({tag, "_wb_pc"}, wb_pc, 0);
      checkOutput({tag, "_wb_rw_en"}, wb_rw_en, 0);
      checkOutput({tag, "_wb_rw_addr"}, wb_rw_addr, 0);
      checkOutput({tag, "_wb_rw_data"}, wb_rw_data, 0);
`ifdef MEM_ALE_CHECK_EN
      checkOutput({tag, "_ale"}, ale, 0);
`endif
   endtask

   function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                               input logic [31:0] rdata, input logic [4:0] rw_addr, input int rdly,
                               input int sdly, input bit hold, input logic [31:0] eaddr,
                               input logic [31:0] ewdata, input logic [3:0] ewstrb,
                               input logic [31:0] erw, input bit eale);
      vec_t v;
      v.op = op; v.addr = addr; v.data = data; v.rdata = rdata;
      v.inst = $urandom; v.pc = $urandom; v.rw_en = 1'b1; v.rw_addr = rw_addr;
      v.ready_dly = rdly; v.rsp_dly = sdly; v.hold_valid = hold;
      v.exp_addr = eaddr; v.exp_wdata = ewdata; v.exp_wstrb = ewstrb;
      v.exp_rw_data = erw; v.exp_ale = eale;
      return v;
   endfunction

   // Reference model: derives request and writeback values from the op table with plain arithmetic.
   function automatic vec_t modelExpect(input vec_t v);
      vec_t        r = v;
      int          lane = int'(v.addr[1:0]);
      bit          isHalf = (v.op == 2) || (v.op == 5) || (v.op == 7);
      bit          isWord = (v.op == 3) || (v.op == 8);
      bit          isMem  = (v.op >= 1) && (v.op <= 8);
      logic [31:0] word;
      r.exp_ale = 0; r.exp_wdata = 0; r.exp_wstrb = 0; r.exp_rw_data = 0;
      r.exp_addr = v.addr;
`ifdef MEM_ALE_CHECK_EN
      if (isMem && ((isHalf && (lane % 2 == 1)) || (isWord && lane != 0))) begin
         r.exp_ale = 1;
         return r;
      end
`endif
      if (isHalf) lane = lane - (lane % 2);
      if (isWord) lane = 0;
      r.exp_addr = (v.addr & 32'hFFFF_FFFC) + 32'(lane);
      word = v.rdata >> (8 * lane);
      case (v.op)
         4'd1: r.exp_rw_data = word[7]  ? ((word & 32'hFF)   | 32'hFFFF_FF00) : (word & 32'hFF);
         4'd2: r.exp_rw_data = word[15] ? ((word & 32'hFFFF) | 32'hFFFF_0000) : (word & 32'hFFFF);
         4'd3: r.exp_rw_data = v.rdata;
         4'd4: r.exp_rw_data = word & 32'hFF;
         4'd5: r.exp_rw_data = word & 32'hFFFF;
         4'd6: begin r.exp_wdata = (v.data & 32'hFF) * 32'h0101_0101;   r.exp_wstrb = 4'b0001 << lane; end
         4'd7: begin r.exp_wdata = (v.data & 32'hFFFF) * 32'h0001_0001; r.exp_wstrb = 4'b0011 << lane; end
         4'd8: begin r.exp_wdata = v.data; r.exp_wstrb = 4'b1111; end
         default: r.exp_rw_data = v.addr;
      endcase
      return r;
   endfunction

   task automatic applyStimulus(input vec_t v);
      bit isLoad  = (v.op >= 1) && (v.op <= 5);
      bit isStore = (v.op >= 6) && (v.op <= 8);
      bit dataChk = !isStore && !v.exp_ale;
      checkOutput("in_ready_idle", in_ready, 1);
      in_valid = 1; in_inst = v.inst; in_pc = v.pc; in_ex_result = v.addr;
      in_rw_en = v.rw_en; in_rw_addr = v.rw_addr; in_lsu_data = v.data; in_lsu_op = v.op;
      tick();
      if (v.hold_valid) begin
         in_inst = ~v.inst; in_lsu_op = 4'd0; in_ex_result = 32'hFFFF_FFFF;
      end else begin
         in_valid = 0;
      end
      if ((isLoad || isStore) && !v.exp_ale) begin
         for (int i = 0; i <= v.ready_dly; i++) begin
            checkOutput("dreq_valid", dreq_valid, 1);
            checkOutput("dreq_addr", dreq_addr, v.exp_addr);
            checkOutput("dreq_we", dreq_we, isStore);
            checkOutput("dreq_wstrb", dreq_wstrb, v.exp_wstrb);
            if (isStore) checkOutput("dreq_wdata", dreq_wdata, v.exp_wdata);
            checkOutput("in_ready_req", in_ready, 0);
            checkOutput("wb_valid_req", wb_valid, 0);
            dreq_ready = (i == v.ready_dly);
            drsp_valid = 1'($urandom_range(0, 1));
            drsp_rdata = $urandom;
            tick();
         end
         dreq_ready = 0; drsp_valid = 0;
         checkOutput("dreq_valid_drop", dreq_valid, 0);
         if (isLoad) begin
            for (int i = 0; i <= v.rsp_dly; i++) begin
               checkOutput("wb_valid_wait", wb_valid, 0);
               checkOutput("in_ready_wait", in_ready, 0);
               drsp_valid = (i == v.rsp_dly);
               drsp_rdata = drsp_valid ? v.rdata : $urandom;
               tick();
            end
            drsp_valid = 0;
         end
      end
      in_valid = 0;
      checkOutput("wb_valid", wb_valid, 1);
      checkOutput("wb_inst", wb_inst, v.inst);
      checkOutput("wb_pc", wb_pc, v.pc);
      checkOutput("wb_rw_addr", wb_rw_addr, v.rw_addr);
      checkOutput("wb_rw_en", wb_rw_en, (isStore || v.exp_ale) ? 1'b0 : v.rw_en);
      if (dataChk) checkOutput("wb_rw_data", wb_rw_data, v.exp_rw_data);
      checkOutput("in_ready_retire", in_ready, 1);
      if (v.exp_ale) checkOutput("dreq_valid_ale", dreq_valid, 0);
`ifdef MEM_ALE_CHECK_EN
      checkOutput("ale", ale, v.exp_ale);
`endif
      tick();
      checkOutput("wb_valid_pulse", wb_valid, 0);
      if (dataChk) checkOutput("wb_rw_data_hold", wb_rw_data, v.exp_rw_data);
`ifdef MEM_ALE_CHECK_EN
      checkOutput("ale_pulse", ale, 0);
`endif
   endtask

   initial begin
      vec_t v;
      logic [31:0] b2b [3];
      rst = 1; in_valid = 0; in_inst = 0; in_pc = 0; in_ex_result = 0; in_rw_en = 0;
      in_rw_addr = 0; in_lsu_data = 0; in_lsu_op = 0; dreq_ready = 0; drsp_valid = 0; drsp_rdata = 0;
      #2 rst = 0;
      tick();
      tick();
      checkAllZero("reset");
      rst = 1;
      tick();
      checkOutput("in_ready_after_reset", in_ready, 1);

      vecs.push_back(mk(4'd0, 32'h1234, 0, 0, 5'd5, 0, 0, 0, 0, 0, 0, 32'h1234, 0));
      vecs.push_back(mk(4'd6, 32'h1003, 32'hAB, 0, 5'd1, 2, 0, 0, 32'h1003, 32'hABAB_ABAB, 4'b1000, 0, 0));
      vecs.push_back(mk(4'd1, 32'h2001, 0, 32'h0000_8000, 5'd2, 0, 0, 0, 32'h2001, 0, 0, 32'hFFFF_FF80, 0));
      vecs.push_back(mk(4'd4, 32'h2001, 0, 32'h0000_8000, 5'd3, 0, 0, 0, 32'h2001, 0, 0, 32'h0000_0080, 0));
      vecs.push_back(mk(4'd5, 32'h2002, 0, 32'hBEEF_0000, 5'd4, 0, 0, 0, 32'h2002, 0, 0, 32'h0000_BEEF, 0));
      vecs.push_back(mk(4'd3, 32'h2004, 0, 32'h1234_5678, 5'd6, 0, 2, 1, 32'h2004, 0, 0, 32'h1234_5678, 0));
      vecs.push_back(mk(4'd7, 32'h1006, 32'h1234_CDEF, 0, 5'd7, 0, 0, 0, 32'h1006, 32'hCDEF_CDEF, 4'b1100, 0, 0));
      vecs.push_back(mk(4'd8, 32'h1008, 32'hDEAD_BEEF, 0, 5'd8, 1, 0, 0, 32'h1008, 32'hDEAD_BEEF, 4'b1111, 0, 0));
      vecs.push_back(mk(4'd2, 32'h200A, 0, 32'h8001_0000, 5'd9, 0, 1, 0, 32'h200A, 0, 0, 32'hFFFF_8001, 0));
      vecs.push_back(mk(4'd9, 32'h0055, 0, 0, 5'd10, 0, 0, 0, 0, 0, 0, 32'h0055, 0));
      vecs.push_back(mk(4'd1, 32'h2003, 0, 32'h7F00_0000, 5'd11, 0, 0, 0, 32'h2003, 0, 0, 32'h0000_007F, 0));
      vecs.push_back(mk(4'd0, 32'hCAFE, 0, 0, 5'd31, 0, 0, 0, 0, 0, 0, 32'hCAFE, 0));
`ifdef MEM_ALE_CHECK_EN
      vecs.push_back(mk(4'd3, 32'h3002, 0, 32'hCAFE_F00D, 5'd12, 0, 0, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(4'd7, 32'h1001, 32'hBEEF, 0, 5'd13, 0, 0, 0, 0, 0, 0, 0, 1));
`else
      vecs.push_back(mk(4'd3, 32'h3002, 0, 32'hCAFE_F00D, 5'd12, 0, 0, 0, 32'h3000, 0, 0, 32'hCAFE_F00D, 0));
      vecs.push_back(mk(4'd7, 32'h1001, 32'hBEEF, 0, 5'd13, 0, 0, 0, 32'h1000, 32'hBEEF_BEEF, 4'b0011, 0, 0));
`endif
      foreach (vecs[i]) applyStimulus(vecs[i]);

      // Back-to-back NONE ops must retire one per cycle.
      b2b[0] = 32'h1111; b2b[1] = 32'h2222; b2b[2] = 32'h3333;
      in_valid = 1; in_lsu_op = 4'd0; in_rw_en = 1;
      for (int i = 0; i < 3; i++) begin
         in_ex_result = b2b[i]; in_rw_addr = 5'(i + 1); in_inst = 32'(i); in_pc = 32'(i * 4);
         tick();
         checkOutput("b2b_wb_valid", wb_valid, 1);
         checkOutput("b2b_wb_rw_data", wb_rw_data, b2b[i]);
         checkOutput("b2b_in_ready", in_ready, 1);
      end
      in_valid = 0;
      tick();
      checkOutput("b2b_wb_valid_end", wb_valid, 0);

      // Reset while waiting for load data; the late response must be discarded.
      in_valid = 1; in_lsu_op = 4'd3; in_ex_result = 32'h2010; in_rw_en = 1; in_rw_addr = 5'd20;
      tick();
      in_valid = 0; dreq_ready = 1;
      tick();
      dreq_ready = 0;
      checkOutput("rstwait_in_ready", in_ready, 0);
      #2 rst = 0;
      #1 checkAllZero("rstwait");
      tick();
      rst = 1;
      tick();
      drsp_valid = 1; drsp_rdata = 32'h5A5A_5A5A;
      tick();
      drsp_valid = 0;
      checkOutput("rstwait_stale_rsp", wb_valid, 0);
      checkOutput("rstwait_in_ready_after", in_ready, 1);
      tick();
      checkOutput("rstwait_stale_rsp2", wb_valid, 0);

      for (int n = 0; n < 150; n++) begin
         v.op = 4'($urandom_range(0, 15));
         v.addr = $urandom; v.data = $urandom; v.rdata = $urandom;
         v.inst = $urandom; v.pc = $urandom; v.rw_en = 1'($urandom_range(0, 1));
         v.rw_addr = 5'($urandom_range(0, 31));
         v.ready_dly = $urandom_range(0, 3); v.rsp_dly = $urandom_range(0, 3);
         v.hold_valid = 1'($urandom_range(0, 1));
         applyStimulus(modelExpect(v));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
